lsu_mem_if: RTL and testbench

- Load/store initiator that turns one CPU memory request into accesses on the byte-enabled, 64-bit, doubleword-aligned data RAM port.
- Sits between the execute stage and the data RAM.
- Performs byte-lane alignment, byte-enable generation and read-modify-write-free stores (the RAM merges by byte enable).
- Splits accesses that cross an 8-byte boundary into two RAM accesses; sign/zero-extends load results.
- Returns one response per request.

---
 rtl/lsu_mem_if_pkg.sv | 58 +++++
 rtl/lsu_mem_if_align.sv | 85 ++++++++
 rtl/lsu_mem_if.sv | 169 ++++++++++++++++
 tb/tb_lsu_mem_if.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_if_pkg.sv
// ----------------------------------------------------------------------------
// lsu_mem_if_pkg
// Shared definitions for the load/store memory interface:
//   - XLEN (data/address width of the core and the RAM port)
//   - RISC-V load/store funct3 encodings
//   - FSM state encoding of lsu_mem_if
//   - small helpers for access size, doubleword crossing and legality
// ----------------------------------------------------------------------------
package lsu_mem_if_pkg;

  localparam int XLEN = 64;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Access size in bytes (1/2/4/8) from funct3[1:0].
  function automatic logic [3:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // True when the access spills past the end of its doubleword.
  // Max sum is 7 + 8 = 15, so 4 bits never overflow.
  function automatic logic crosses_dword(input logic [2:0] funct3,
                                         input logic [2:0] offset);
    return ({1'b0, offset} + access_bytes(funct3)) > 4'd8;
  endfunction

  // Loads have no 3'b111 encoding; stores only use sizes (funct3[2] = 0).
  function automatic logic is_illegal(input logic       we,
                                      input logic [2:0] funct3);
    return we ? (funct3 > F3_SD) : (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_mem_if_align.sv
// ----------------------------------------------------------------------------
// lsu_align
// Combinational byte-lane steering for lsu_mem_if.
//   Store side: byte enables and lane-aligned write data for the first
//   (byte_en0/lanes0) and second (byte_en1/lanes1) doubleword of an access.
//   Load side: extracts the addressed bytes from {hi,lo} and sign/zero-extends
//   them according to funct3.
// Ports:
//   funct3    in   3     size/sign of the access
//   offset    in   3     byte offset inside the doubleword (addr[2:0])
//   wdata     in   XLEN  right-justified store data
//   hi, lo    in   XLEN  raw RAM read data of second/first doubleword
//   byte_en0  out  8     byte enables, first doubleword
//   byte_en1  out  8     byte enables, second doubleword
//   lanes0    out  XLEN  write data, first doubleword
//   lanes1    out  XLEN  write data, second doubleword
//   rdata_ext out  XLEN  extended load result
// ----------------------------------------------------------------------------
module lsu_align
  import lsu_mem_if_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  output logic [7:0]      byte_en0,
  output logic [7:0]      byte_en1,
  output logic [XLEN-1:0] lanes0,
  output logic [XLEN-1:0] lanes1,
  output logic [XLEN-1:0] rdata_ext
);

  logic [7:0]        size_mask;
  logic [XLEN-1:0]   data_mask;
  logic [5:0]        bit_off;
  logic [15:0]       be_wide;
  logic [2*XLEN-1:0] wd_wide;
  logic [XLEN-1:0]   rd_shift;
  logic signed [7:0]  ld_b;
  logic signed [15:0] ld_h;
  logic signed [31:0] ld_w;

  always_comb begin
    size_mask = 8'hFF;
    data_mask = '1;
    case (funct3[1:0])
      2'b00: begin size_mask = 8'h01; data_mask = XLEN'(64'h0000_0000_0000_00FF); end
      2'b01: begin size_mask = 8'h03; data_mask = XLEN'(64'h0000_0000_0000_FFFF); end
      2'b10: begin size_mask = 8'h0F; data_mask = XLEN'(64'h0000_0000_FFFF_FFFF); end
      default: begin size_mask = 8'hFF; data_mask = '1; end
    endcase
  end

  assign bit_off = {offset, 3'b000};

  // Masks and data are built in a 16-byte window so the spill into the next
  // doubleword falls out of the shift naturally.
  assign be_wide  = {8'h00, size_mask} << offset;
  assign wd_wide  = {{XLEN{1'b0}}, wdata & data_mask} << bit_off;
  assign byte_en0 = be_wide[7:0];
  assign byte_en1 = be_wide[15:8];
  assign lanes0   = wd_wide[XLEN-1:0];
  assign lanes1   = wd_wide[2*XLEN-1:XLEN];

  assign rd_shift = XLEN'({hi, lo} >> bit_off);
  assign ld_b     = rd_shift[7:0];
  assign ld_h     = rd_shift[15:0];
  assign ld_w     = rd_shift[31:0];

  always_comb begin
    rdata_ext = '0;
    case (funct3)
      F3_LB:   rdata_ext = XLEN'(ld_b);
      F3_LH:   rdata_ext = XLEN'(ld_h);
      F3_LW:   rdata_ext = XLEN'(ld_w);
      F3_LD:   rdata_ext = rd_shift;
      F3_LBU:  rdata_ext = XLEN'(rd_shift[7:0]);
      F3_LHU:  rdata_ext = XLEN'(rd_shift[15:0]);
      F3_LWU:  rdata_ext = XLEN'(rd_shift[31:0]);
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// ----------------------------------------------------------------------------
// lsu_mem_if
// Load/store initiator between the execute stage and a byte-enabled,
// doubleword-wide data RAM. Accepts one request at a time, splits accesses
// that cross a doubleword boundary into two RAM cycles (SPLIT_EN=1) or
// rejects them (SPLIT_EN=0), and returns exactly one response per request.
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   req_valid_i/ready_o request handshake
//   req_we_i            1 = store, 0 = load
//   req_funct3_i        RISC-V funct3 (size/sign)
//   req_addr_i          byte address
//   req_wdata_i         right-justified store data
//   resp_valid_o/ready_i response handshake
//   resp_rdata_o        extended load data (0 for stores and errors)
//   resp_err_o          illegal funct3 or blocked crossing access
//   mem_addr_o          doubleword-aligned RAM address
//   mem_wen_o/ren_o     RAM write / read enable
//   mem_byte_en_o       RAM byte enables
//   mem_wdata_o         lane-aligned write data
//   mem_rdata_i         RAM read data (combinational from address/enable)
// ----------------------------------------------------------------------------
module lsu_mem_if
  import lsu_mem_if_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_wen_o,
  output logic [7:0]      mem_byte_en_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic            mem_ren_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  lsu_state_e      state_q, state_d;

  logic            we_p0;
  logic [2:0]      funct3_p0;
  logic [XLEN-1:0] addr_p0;
  logic [XLEN-1:0] wdata_p0;
  logic            err_p0;
  logic [XLEN-1:0] lo_p1;
  logic [XLEN-1:0] hi_p1;

  logic            req_fire;
  logic            req_err;
  logic            cross_p0;
  logic [XLEN-1:0] addr_base;
  logic [XLEN-1:0] addr_next;

  logic [7:0]      byte_en0, byte_en1;
  logic [XLEN-1:0] lanes0, lanes1;
  logic [XLEN-1:0] rdata_ext;

  lsu_align u_align (
    .funct3    (funct3_p0),
    .offset    (addr_p0[2:0]),
    .wdata     (wdata_p0),
    .hi        (hi_p1),
    .lo        (lo_p1),
    .byte_en0  (byte_en0),
    .byte_en1  (byte_en1),
    .lanes0    (lanes0),
    .lanes1    (lanes1),
    .rdata_ext (rdata_ext)
  );

  assign req_fire  = (state_q == ST_IDLE) && req_valid_i;
  assign req_err   = is_illegal(req_we_i, req_funct3_i) ||
                     (!SPLIT_EN && crosses_dword(req_funct3_i, req_addr_i[2:0]));
  assign cross_p0  = crosses_dword(funct3_p0, addr_p0[2:0]);
  assign addr_base = {addr_p0[XLEN-1:3], 3'b000};
  assign addr_next = addr_base + XLEN'(8);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      we_p0     <= 1'b0;
      funct3_p0 <= 3'b000;
      addr_p0   <= '0;
      wdata_p0  <= '0;
      err_p0    <= 1'b0;
      lo_p1     <= '0;
      hi_p1     <= '0;
    end else begin
      state_q <= state_d;
      // request capture stage
      if (req_fire) begin
        we_p0     <= req_we_i;
        funct3_p0 <= req_funct3_i;
        addr_p0   <= req_addr_i;
        wdata_p0  <= req_wdata_i;
        err_p0    <= req_err;
        lo_p1     <= '0;
        hi_p1     <= '0;
      end
      // RAM access stage: hi stays 0 for unsplit loads
      if (state_q == ST_ACC0 && !we_p0) lo_p1 <= mem_rdata_i;
      if (state_q == ST_ACC1 && !we_p0) hi_p1 <= mem_rdata_i;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready_o   = 1'b0;
    resp_valid_o  = 1'b0;
    resp_rdata_o  = '0;
    resp_err_o    = 1'b0;
    mem_addr_o    = '0;
    mem_wen_o     = 1'b0;
    mem_ren_o     = 1'b0;
    mem_byte_en_o = 8'h00;
    mem_wdata_o   = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = req_err ? ST_RESP : ST_ACC0;
      end
      ST_ACC0: begin
        mem_addr_o    = addr_base;
        mem_byte_en_o = byte_en0;
        if (we_p0) begin
          mem_wen_o   = 1'b1;
          mem_wdata_o = lanes0;
        end else begin
          mem_ren_o   = 1'b1;
        end
        state_d = cross_p0 ? ST_ACC1 : ST_RESP;
      end
      ST_ACC1: begin
        mem_addr_o    = addr_next;
        mem_byte_en_o = byte_en1;
        if (we_p0) begin
          mem_wen_o   = 1'b1;
          mem_wdata_o = lanes1;
        end else begin
          mem_ren_o   = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_p0;
        resp_rdata_o = (we_p0 || err_p0) ? '0 : rdata_ext;
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset aborts at once: an access cycle in flight must not commit.
    mem_wen_o = mem_wen_o & rst_n;
    mem_ren_o = mem_ren_o & rst_n;
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
module tb_lsu_mem_if;
  import lsu_mem_if_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            req_valid, req_ready, req_we;
  logic [2:0]      req_f3;
  logic [63:0]     req_addr, req_wdata;
  logic            resp_valid, resp_ready, resp_err;
  logic [63:0]     resp_rdata;
  logic [63:0]     mem_addr, mem_wdata, mem_rdata;
  logic            mem_wen, mem_ren;
  logic [7:0]      mem_be;

  logic            b_req_valid, b_req_ready, b_resp_valid, b_resp_err;
  logic [63:0]     b_resp_rdata, b_mem_addr, b_mem_wdata;
  logic            b_mem_wen, b_mem_ren;
  logic [7:0]      b_mem_be;
  logic [63:0]     b_mem_rdata;

  lsu_mem_if #(.SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_addr_o(mem_addr), .mem_wen_o(mem_wen), .mem_byte_en_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_ren_o(mem_ren), .mem_rdata_i(mem_rdata)
  );

  lsu_mem_if #(.SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(req_we),
    .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(b_resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(b_resp_rdata), .resp_err_o(b_resp_err),
    .mem_addr_o(b_mem_addr), .mem_wen_o(b_mem_wen), .mem_byte_en_o(b_mem_be),
    .mem_wdata_o(b_mem_wdata), .mem_ren_o(b_mem_ren), .mem_rdata_i(b_mem_rdata)
  );

  assign b_mem_rdata = 64'h0;

  // RAM: 64 doublewords, byte-merging writes at the clock edge
  logic [63:0] ram [0:63];
  assign mem_rdata = ram[mem_addr[8:3]];
  always @(posedge clk) begin
    if (mem_wen)
      for (int i = 0; i < 8; i++)
        if (mem_be[i]) ram[mem_addr[8:3]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  int both_cnt = 0;
  int b_acc_cnt = 0;
  always @(negedge clk) begin
    if (mem_wen && mem_ren) both_cnt++;
    if (b_mem_wen || b_mem_ren) b_acc_cnt++;
  end

  // Reference model: flat byte memory, 512 bytes, wrapping
  logic [7:0] ref_mem [0:511];

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] addr);
    logic [63:0] v;
    int n;
    v = 64'h0;
    n = nbytes(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(addr[8:0]) + i) % 512];
    if (!f3[2] && v[8*n-1])
      for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wd);
    for (int i = 0; i < nbytes(f3); i++) ref_mem[(int'(addr[8:0]) + i) % 512] = wd[8*i +: 8];
  endtask

  function automatic logic [63:0] ref_word(input int idx);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_mem[idx*8 + i];
    return w;
  endfunction

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // access log of the last request
  int          n_acc;
  logic [63:0] acc_addr [2];
  logic [63:0] acc_wd   [2];
  logic [7:0]  acc_be   [2];

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, output int lat,
                        output logic [63:0] rd, output logic er);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
    resp_ready = 1'b1;
    n_acc = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      if ((mem_wen || mem_ren) && n_acc < 2) begin
        acc_addr[n_acc] = mem_addr; acc_wd[n_acc] = mem_wdata; acc_be[n_acc] = mem_be;
        n_acc++;
      end
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    if (!resp_valid) chk("resp_timeout", 64'(resp_valid), 64'd1);
    @(posedge clk); #1;
  endtask

  int          lat;
  logic [63:0] rd, wd, addr, rand_exp;
  logic        er, we;
  logic [2:0]  f3;
  int          exp_lat;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; b_req_valid = 1'b0; req_we = 1'b0;
    req_f3 = 3'b0; req_addr = 64'h0; req_wdata = 64'h0; resp_ready = 1'b1;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) ram[i] = ref_word(i);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_mem_en", {62'd0, mem_wen, mem_ren}, 64'd0);
    chk("rst_mem_be", 64'(mem_be), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_b_req_ready", 64'(b_req_ready), 64'd1);
    rst_n = 1'b1;

    // aligned SD then LD
    do_req(1'b1, F3_SD, 64'h10, 64'h1122334455667788, lat, rd, er);
    ref_store(F3_SD, 64'h10, 64'h1122334455667788);
    chk("sd_lat", 64'(lat), 64'd2);
    chk("sd_nacc", 64'(n_acc), 64'd1);
    chk("sd_addr", acc_addr[0], 64'h10);
    chk("sd_be", 64'(acc_be[0]), 64'hFF);
    chk("sd_wdata", acc_wd[0], 64'h1122334455667788);
    chk("sd_rdata", rd, 64'h0);
    do_req(1'b0, F3_LD, 64'h10, 64'h0, lat, rd, er);
    chk("ld_lat", 64'(lat), 64'd2);
    chk("ld_rdata", rd, 64'h1122334455667788);
    chk("ld_err", 64'(er), 64'd0);

    // byte store/loads at offset 3; upper wdata bits must be ignored
    do_req(1'b1, F3_SB, 64'h13, 64'h55AB, lat, rd, er);
    ref_store(F3_SB, 64'h13, 64'hAB);
    chk("sb_addr", acc_addr[0], 64'h10);
    chk("sb_be", 64'(acc_be[0]), 64'h08);
    chk("sb_wdata", acc_wd[0], 64'h00000000AB000000);
    do_req(1'b0, F3_LB, 64'h13, 64'h0, lat, rd, er);
    chk("lb_rdata", rd, 64'hFFFFFFFFFFFFFFAB);
    do_req(1'b0, F3_LBU, 64'h13, 64'h0, lat, rd, er);
    chk("lbu_rdata", rd, 64'h00000000000000AB);

    // split word store across 0x18/0x20
    do_req(1'b1, F3_SW, 64'h1E, 64'hDEADBEEF, lat, rd, er);
    ref_store(F3_SW, 64'h1E, 64'hDEADBEEF);
    chk("sw_split_lat", 64'(lat), 64'd3);
    chk("sw_split_nacc", 64'(n_acc), 64'd2);
    chk("sw_acc0_addr", acc_addr[0], 64'h18);
    chk("sw_acc0_be", 64'(acc_be[0]), 64'hC0);
    chk("sw_acc0_wdata", acc_wd[0], 64'hBEEF000000000000);
    chk("sw_acc1_addr", acc_addr[1], 64'h20);
    chk("sw_acc1_be", 64'(acc_be[1]), 64'h03);
    chk("sw_acc1_wdata", acc_wd[1], 64'h000000000000DEAD);
    do_req(1'b0, F3_LW, 64'h1E, 64'h0, lat, rd, er);
    chk("lw_split_lat", 64'(lat), 64'd3);
    chk("lw_split_rdata", rd, 64'hFFFFFFFFDEADBEEF);

    // illegal store funct3 on the splitting instance
    do_req(1'b1, 3'b100, 64'h20, 64'h1, lat, rd, er);
    chk("st_ill_lat", 64'(lat), 64'd1);
    chk("st_ill_err", 64'(er), 64'd1);
    chk("st_ill_nacc", 64'(n_acc), 64'd0);

    // same split store on the SPLIT_EN=0 instance
    @(negedge clk);
    b_req_valid = 1'b1; req_we = 1'b1; req_f3 = F3_SW; req_addr = 64'h1E;
    req_wdata = 64'hDEADBEEF; resp_ready = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    chk("ns_resp_valid_t1", 64'(b_resp_valid), 64'd1);
    chk("ns_err", 64'(b_resp_err), 64'd1);
    chk("ns_rdata", b_resp_rdata, 64'h0);
    @(posedge clk); #1;
    chk("ns_back_idle", 64'(b_req_ready), 64'd1);
    chk("ns_no_mem_access", 64'(b_acc_cnt), 64'd0);

    // illegal load held in RESP by back-pressure
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'b111; req_addr = 64'h8; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("ill_ld_valid", 64'(resp_valid), 64'd1);
    chk("ill_ld_err", 64'(resp_err), 64'd1);
    chk("ill_ld_rdata", resp_rdata, 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_err", 64'(resp_err), 64'd1);
      chk("hold_rdata", resp_rdata, 64'h0);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_ready", 64'(req_ready), 64'd1);
    chk("hold_release_valid", 64'(resp_valid), 64'd0);

    // random traffic against the byte-memory model
    for (int t = 0; t < 40; t++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      addr = 64'($urandom_range(0, 511));
      wd   = {$urandom, $urandom};
      exp_lat  = ((int'(addr[2:0]) + nbytes(f3)) > 8) ? 3 : 2;
      rand_exp = we ? 64'h0 : ref_load(f3, addr);
      do_req(we, f3, addr, wd, lat, rd, er);
      if (we) ref_store(f3, addr, wd);
      chk("rand_lat", 64'(lat), 64'(exp_lat));
      chk("rand_rdata", rd, rand_exp);
      chk("rand_err", 64'(er), 64'd0);
    end

    // reset during ACC1 of a split doubleword store at 0x3C
    wd = {$urandom, $urandom};
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_f3 = F3_SD; req_addr = 64'h3C; req_wdata = wd;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_split_acc0_wen", 64'(mem_wen), 64'd1);
    @(posedge clk); #1;
    chk("rst_split_acc1_addr", mem_addr, 64'h40);
    rst_n = 1'b0;
    #1;
    chk("rst_split_wen_gated", 64'(mem_wen), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_split_req_ready", 64'(req_ready), 64'd1);
    chk("rst_split_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_split_mem_wen", 64'(mem_wen), 64'd0);
    for (int i = 0; i < 4; i++) ref_mem[16'h3C + i] = wd[8*i +: 8];
    chk("rst_split_low_word", ram[7], ref_word(7));
    chk("rst_split_high_word", ram[8], ref_word(8));
    do_req(1'b0, F3_LD, 64'h3C, 64'h0, lat, rd, er);
    chk("rst_split_readback", rd, ref_load(F3_LD, 64'h3C));

    chk("wen_ren_exclusive", 64'(both_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
